// File: rtl/edc_pkg.sv
// Shared encodings and constants for the EDC scrubber.
package edc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RD,
    ST_WB,
    ST_NEXT
  } scrub_state_t;

  typedef enum logic {
    OWN_M = 1'b0,
    OWN_S = 1'b1
  } owner_t;

  localparam logic [15:0] SAT_MAX = 16'hFFFF;

  // Word-stepping address with wrap back to the window base.
  function automatic logic [31:0] next_adr(input logic [31:0] adr,
                                           input logic [31:0] base,
                                           input logic [31:0] last);
    return (adr == last) ? base : adr + 32'd4;
  endfunction

endpackage

// File: rtl/edc_sat_cnt.sv
// 16-bit event counter that sticks at its maximum value.
module edc_sat_cnt
  import edc_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != SAT_MAX)) begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/edc_scrubber.sv
// Background scrubber sharing a Wishbone EDC memory port with a core master.
module edc_scrubber
  import edc_pkg::*;
#(
  parameter int unsigned WB_DWIDTH      = 32,
  parameter int unsigned WB_SWIDTH      = 4,
  parameter logic [31:0] SCRUB_BASE     = 32'h0000_0000,
  parameter int unsigned SCRUB_WORDS    = 1024,
  parameter int unsigned SCRUB_INTERVAL = 256
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_scrub_en,
  input  logic [31:0]          i_m_adr,
  input  logic [WB_SWIDTH-1:0] i_m_sel,
  input  logic                 i_m_we,
  input  logic [WB_DWIDTH-1:0] i_m_dat,
  input  logic                 i_m_cyc,
  input  logic                 i_m_stb,
  output logic [WB_DWIDTH-1:0] o_m_dat,
  output logic                 o_m_ack,
  output logic                 o_m_err,
  output logic [31:0]          o_s_adr,
  output logic [WB_SWIDTH-1:0] o_s_sel,
  output logic                 o_s_we,
  output logic [WB_DWIDTH-1:0] o_s_dat,
  output logic                 o_s_cyc,
  output logic                 o_s_stb,
  input  logic [WB_DWIDTH-1:0] i_s_dat,
  input  logic                 i_s_ack,
  input  logic                 i_s_err,
  input  logic                 i_s_ced,
  output logic [15:0]          o_ce_count,
  output logic [15:0]          o_ue_count,
  output logic                 o_scrub_busy
);

  localparam logic [31:0]   SCRUB_LAST = SCRUB_BASE + 32'(4 * (SCRUB_WORDS - 1));
  localparam int unsigned   IW         = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
  localparam logic [IW-1:0] IV_LAST    = IW'(SCRUB_INTERVAL - 1);

  scrub_state_t         state;
  owner_t               owner;
  logic [31:0]          scrub_adr;
  logic [IW-1:0]        ivl_cnt;
  logic                 sc_cyc;
  logic                 sc_we;
  logic [WB_DWIDTH-1:0] sc_dat;
  logic                 ce_inc;
  logic                 ue_inc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= ST_IDLE;
      owner     <= OWN_M;
      scrub_adr <= SCRUB_BASE;
      ivl_cnt   <= '0;
      sc_cyc    <= 1'b0;
      sc_we     <= 1'b0;
      sc_dat    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_scrub_en) begin
            state   <= ST_WAIT;
            ivl_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (!i_scrub_en) begin
            state <= ST_IDLE;
          end else if (ivl_cnt != IV_LAST) begin
            ivl_cnt <= ivl_cnt + IW'(1);
          end else if (!i_m_cyc) begin
            // Expired and the master is idle: grab the bus. A busy master keeps it.
            owner   <= OWN_S;
            sc_cyc  <= 1'b1;
            sc_we   <= 1'b0;
            ivl_cnt <= '0;
            state   <= ST_RD;
          end
        end
        ST_RD: begin
          if (i_s_err) begin
            sc_cyc <= 1'b0;
            state  <= ST_NEXT;
          end else if (i_s_ack) begin
            sc_dat <= i_s_dat;
            if (i_s_ced) begin
              sc_we <= 1'b1;
              state <= ST_WB;
            end else begin
              sc_cyc <= 1'b0;
              state  <= ST_NEXT;
            end
          end
        end
        ST_WB: begin
          if (i_s_ack || i_s_err) begin
            sc_cyc <= 1'b0;
            sc_we  <= 1'b0;
            state  <= ST_NEXT;
          end
        end
        ST_NEXT: begin
          owner     <= OWN_M;
          sc_we     <= 1'b0;
          scrub_adr <= next_adr(scrub_adr, SCRUB_BASE, SCRUB_LAST);
          ivl_cnt   <= '0;
          state     <= i_scrub_en ? ST_WAIT : ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign ce_inc = (state == ST_RD) && i_s_ack && !i_s_err && i_s_ced;
  assign ue_inc = (state == ST_RD) && i_s_err;

  edc_sat_cnt u_ce_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (ce_inc),
    .count (o_ce_count)
  );

  edc_sat_cnt u_ue_cnt (
    .clk   (i_clk),
    .rst_n (i_rst_n),
    .inc   (ue_inc),
    .count (o_ue_count)
  );

  assign o_scrub_busy = (owner == OWN_S);

  always_comb begin
    o_m_dat = i_s_dat;
    o_m_ack = (owner == OWN_M) && i_s_ack;
    o_m_err = (owner == OWN_M) && i_s_err;

    o_s_adr = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    o_s_dat = '0;
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    if (!i_rst_n) begin
      // Downstream request is forced quiet while reset is held.
    end else if (owner == OWN_M) begin
      o_s_adr = i_m_adr;
      o_s_sel = i_m_sel;
      o_s_we  = i_m_we;
      o_s_dat = i_m_dat;
      o_s_cyc = i_m_cyc;
      o_s_stb = i_m_stb;
    end else begin
      o_s_adr = scrub_adr;
      o_s_sel = '1;
      o_s_we  = sc_we;
      o_s_dat = sc_dat;
      o_s_cyc = sc_cyc;
      o_s_stb = sc_cyc;
    end
  end

endmodule

// File: tb/tb_edc_scrubber.sv
// Scoreboard bench: EDC memory model, random master traffic, scrub sequence model.
module tb_edc_scrubber;
  localparam int unsigned SW    = 4;
  localparam int unsigned WORDS = 3;
  localparam int unsigned IVL   = 4;
  localparam int unsigned MEMW  = 8;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        scrub_en = 1'b0;
  logic [31:0] m_adr = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0;
  logic [31:0] m_dat = '0;
  logic        m_cyc = 1'b0;
  logic        m_stb = 1'b0;
  logic [31:0] om_dat;
  logic        om_ack, om_err;
  logic [31:0] s_adr;
  logic [3:0]  s_sel;
  logic        s_we;
  logic [31:0] s_dat;
  logic        s_cyc, s_stb;
  logic [31:0] s_rdat = '0;
  logic        s_ack = 1'b0, s_err = 1'b0, s_ced = 1'b0;
  logic [15:0] ce_count, ue_count;
  logic        scrub_busy;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem     [MEMW];
  logic [31:0] ref_mem [MEMW];
  bit          sgl     [MEMW];
  bit          dbl     [MEMW];

  typedef struct { bit we; logic [31:0] dat; bit err; } mexp_t;
  typedef struct { bit we; logic [31:0] adr; logic [31:0] dat; } sexp_t;
  mexp_t mq[$];
  sexp_t sq[$];
  int rd_idx = 0, exp_ce = 0, exp_ue = 0, scrub_done = 0;

  edc_scrubber #(
    .WB_DWIDTH      (32),
    .WB_SWIDTH      (SW),
    .SCRUB_BASE     (BASE),
    .SCRUB_WORDS    (WORDS),
    .SCRUB_INTERVAL (IVL)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_scrub_en   (scrub_en),
    .i_m_adr      (m_adr),
    .i_m_sel      (m_sel),
    .i_m_we       (m_we),
    .i_m_dat      (m_dat),
    .i_m_cyc      (m_cyc),
    .i_m_stb      (m_stb),
    .o_m_dat      (om_dat),
    .o_m_ack      (om_ack),
    .o_m_err      (om_err),
    .o_s_adr      (s_adr),
    .o_s_sel      (s_sel),
    .o_s_we       (s_we),
    .o_s_dat      (s_dat),
    .o_s_cyc      (s_cyc),
    .o_s_stb      (s_stb),
    .i_s_dat      (s_rdat),
    .i_s_ack      (s_ack),
    .i_s_err      (s_err),
    .i_s_ced      (s_ced),
    .o_ce_count   (ce_count),
    .o_ue_count   (ue_count),
    .o_scrub_busy (scrub_busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  function automatic void push_next_read();
    sexp_t e;
    e.we  = 1'b0;
    e.adr = BASE + 32'(4 * (rd_idx % int'(WORDS)));
    e.dat = '0;
    rd_idx++;
    sq.push_back(e);
  endfunction

  function automatic void model_reset();
    sq.delete();
    rd_idx = 0;
    exp_ce = 0;
    exp_ue = 0;
    push_next_read();
  endfunction

  // EDC memory: corrected data on reads, ced for single flips, err for double flips.
  initial begin : slave
    int lat;
    bit pend;
    int w;
    lat = 0;
    pend = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_n) begin
        s_ack = 0; s_err = 0; s_ced = 0; pend = 0;
      end else if (s_ack || s_err) begin
        s_ack = 0; s_err = 0; s_ced = 0; pend = 0;
      end else if (s_cyc && s_stb) begin
        if (!pend) begin pend = 1; lat = int'($urandom_range(0, 2)); end
        if (lat > 0) lat--;
        else begin
          w = int'(s_adr[4:2]);
          if (s_we) begin
            for (int b = 0; b < int'(SW); b++)
              if (s_sel[b]) mem[w][8*b +: 8] = s_dat[8*b +: 8];
            sgl[w] = 0; dbl[w] = 0; s_ack = 1;
          end else if (dbl[w]) begin
            s_rdat = $urandom; s_err = 1;
          end else begin
            s_rdat = mem[w]; s_ced = sgl[w]; s_ack = 1;
          end
        end
      end else pend = 0;
    end
  end

  task automatic master_xfer(input bit we, input int w, input logic [31:0] d, input logic [3:0] sel);
    mexp_t e;
    bit done;
    @(posedge clk); #1;
    e.we  = we;
    e.err = dbl[w] && !we;
    e.dat = ref_mem[w];
    if (we)
      for (int b = 0; b < int'(SW); b++)
        if (sel[b]) ref_mem[w][8*b +: 8] = d[8*b +: 8];
    mq.push_back(e);
    m_adr = 32'(w * 4); m_we = we; m_dat = d; m_sel = sel; m_cyc = 1; m_stb = 1;
    done = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (om_ack || om_err) begin done = 1; break; end
    end
    if (!done) mq.delete();
    check("master_timeout", 32'(done), 1);
    m_cyc = 0; m_stb = 0; m_we = 0;
  endtask

  task automatic wait_scrubs(input int n);
    int target;
    bit ok;
    target = scrub_done + n;
    ok = 0;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (scrub_done >= target) begin ok = 1; break; end
    end
    check("scrub_progress", 32'(ok), 1);
  endtask

  always @(negedge clk) begin : master_mon
    mexp_t me;
    if (rst_n) begin
      if (om_ack || om_err) begin
        if (mq.size() == 0) check("m_unexpected_ack", 1, 0);
        else begin
          me = mq.pop_front();
          check("m_err", 32'(om_err), 32'(me.err));
          if (!me.we && !me.err) check("m_rdata", om_dat, me.dat);
        end
      end
      if (scrub_busy && m_cyc) check("m_stall_ack", 32'({om_ack, om_err}), 0);
    end
  end

  always @(negedge clk) begin : scrub_mon
    sexp_t se, wb;
    if (rst_n && scrub_busy && s_cyc && (s_ack || s_err)) begin
      check("s_ce_count", 32'(ce_count), 32'(exp_ce));
      check("s_ue_count", 32'(ue_count), 32'(exp_ue));
      if (sq.size() == 0) check("s_unexpected", 1, 0);
      else begin
        se = sq.pop_front();
        check("s_we", 32'(s_we), 32'(se.we));
        check("s_adr", s_adr, se.adr);
        check("s_sel", 32'(s_sel), 32'hF);
        if (se.we) check("s_wdat", s_dat, se.dat);
        if (!se.we && s_err) begin
          exp_ue = sat16(exp_ue + 1);
          push_next_read();
        end else if (!se.we && s_ced) begin
          exp_ce = sat16(exp_ce + 1);
          wb.we = 1'b1; wb.adr = se.adr; wb.dat = ref_mem[int'(se.adr[4:2])];
          sq.push_back(wb);
        end else push_next_read();
      end
      scrub_done++;
    end
  end

  // Idle spacing between scrub accesses, measured only across undisturbed gaps.
  always @(negedge clk) begin : gap_mon
    static int gap = 0;
    static bit gap_clean = 0, have_prev = 0, prev_busy = 0;
    if (!rst_n) begin
      have_prev = 0; gap = 0;
    end else if (scrub_busy) begin
      if (!prev_busy && have_prev && gap_clean) check("scrub_gap", 32'(gap), 32'(IVL));
      have_prev = 1; gap = 0; gap_clean = 1;
    end else begin
      gap++;
      if (m_cyc || !scrub_en) gap_clean = 0;
    end
    prev_busy = scrub_busy;
  end

  initial begin : main
    bit found;
    int saved;
    for (int i = 0; i < int'(MEMW); i++) begin
      mem[i] = $urandom; ref_mem[i] = mem[i]; sgl[i] = 0; dbl[i] = 0;
    end
    model_reset();
    m_adr = 32'h10; m_cyc = 1; m_stb = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_cyc", 32'(s_cyc), 0);
    check("rst_s_adr", s_adr, 0);
    check("rst_busy", 32'(scrub_busy), 0);
    check("rst_ce", 32'(ce_count), 0);
    check("rst_ue", 32'(ue_count), 0);
    m_adr = '0; m_cyc = 0; m_stb = 0;
    rst_n = 1; scrub_en = 1;

    // Clean memory: read sequence including wrap.
    wait_scrubs(5);
    check("clean_ce", 32'(ce_count), 0);
    check("clean_ue", 32'(ue_count), 0);

    // Single flip at word 2 is written back once.
    sgl[2] = 1;
    wait_scrubs(5);
    check("flip_ce", 32'(ce_count), 1);
    check("flip_cleared", 32'(sgl[2]), 0);

    // Double flip at word 0.
    dbl[0] = 1;
    wait_scrubs(3);
    check("dbl_ue", 32'(ue_count), 1);
    dbl[0] = 0;

    // Disable mid-read: access completes, engine parks.
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (scrub_busy && s_cyc && !s_we) begin found = 1; break; end
    end
    check("wait_rd_dis", 32'(found), 1);
    scrub_en = 0;
    for (int i = 0; i < 50 && scrub_busy; i++) begin @(posedge clk); #1; end
    saved = scrub_done;
    repeat (20) @(posedge clk);
    #1;
    check("dis_busy", 32'(scrub_busy), 0);
    check("dis_no_access", 32'(scrub_done), 32'(saved));
    scrub_en = 1;

    // Master collides with a scrub read.
    found = 0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      if (scrub_busy && s_cyc && !s_we) begin found = 1; break; end
    end
    check("wait_rd_collide", 32'(found), 1);
    master_xfer(0, 1, '0, 4'hF);

    // Random master traffic interleaved with scrubbing.
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 1) == 1)
        master_xfer(1, int'($urandom_range(0, MEMW - 1)), $urandom, 4'($urandom_range(1, 15)));
      else
        master_xfer(0, int'($urandom_range(0, MEMW - 1)), '0, 4'hF);
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end

    // Reset during writeback.
    for (int i = 0; i < int'(WORDS); i++) sgl[i] = 1;
    found = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      if (scrub_busy && s_cyc && s_we) begin found = 1; break; end
    end
    check("wait_wb", 32'(found), 1);
    rst_n = 0;
    #1;
    check("rstwb_s_cyc", 32'(s_cyc), 0);
    check("rstwb_busy", 32'(scrub_busy), 0);
    check("rstwb_ce", 32'(ce_count), 0);
    check("rstwb_ue", 32'(ue_count), 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    wait_scrubs(6);
    check("rstwb_ce_after", 32'(ce_count), 3);
    check("rstwb_flags", 32'({sgl[0], sgl[1], sgl[2]}), 0);

    scrub_en = 0;
    for (int i = 0; i < 50 && scrub_busy; i++) begin @(posedge clk); #1; end
    check("end_ce", 32'(ce_count), 32'(exp_ce));
    check("end_ue", 32'(ue_count), 32'(exp_ue));
    check("end_mq_empty", 32'(mq.size()), 0);
    repeat (5) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
